// File: rtl/chip8_regxfer.sv
// rtl/chip8_regxfer.sv - V-register <-> RAM block transfer engine (store, load, BCD)
module chip8_regxfer #(
  parameter int ADDR_W      = 12,
  parameter int RAM_LATENCY = 1,
  parameter int QUIRK_INC_I = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [3:0]        first,
  input  logic [3:0]        last,
  input  logic [ADDR_W-1:0] base,
  input  logic [7:0]        bcd_val,
  output logic              busy,
  output logic              done,
  output logic [3:0]        reg_rd_idx,
  input  logic [7:0]        reg_rd_data,
  output logic              reg_wr,
  output logic [3:0]        reg_wr_idx,
  output logic [7:0]        reg_wr_data,
  output logic              ram_en,
  output logic              ram_wr,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_in,
  input  logic [7:0]        ram_out,
  output logic              i_wr,
  output logic [ADDR_W-1:0] i_new
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_STORE = 3'd1;
  localparam logic [2:0] ST_LOAD  = 3'd2;
  localparam logic [2:0] ST_BCD   = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  localparam logic [1:0] OP_STORE = 2'd0;
  localparam logic [1:0] OP_LOAD  = 2'd1;
  localparam logic [1:0] OP_BCD   = 2'd2;

  logic [2:0]        state;
  logic [4:0]        cnt;

  // Request fields captured on accept; the CPU may change its inputs afterwards.
  logic [1:0]        op_q;
  logic [3:0]        first_q;
  logic [3:0]        last_q;
  logic [ADDR_W-1:0] base_q;
  logic [7:0]        bcd_q;

  logic              ascending;
  logic [3:0]        span;
  logic [4:0]        count;
  logic [4:0]        beats;
  logic [4:0]        end_cnt;
  logic [3:0]        cur_idx;
  logic [ADDR_W-1:0] cur_addr;
  logic              in_xfer;
  logic              beat_live;
  logic [7:0]        bcd_digit;

  // Register index of the read issued in the current output cycle; it enters
  // the delay line alongside the read strobe.
  logic [3:0]        ld_idx_q;

  logic [RAM_LATENCY-1:0] dl_vld;
  logic [3:0]             dl_idx [RAM_LATENCY];

  // Range geometry, per-beat index/address and the BCD digit for the current beat.
  always_comb begin
    ascending = (first_q <= last_q);
    span      = ascending ? (last_q - first_q) : (first_q - last_q);
    count     = {1'b0, span} + 5'd1;
    cur_idx   = ascending ? (first_q + cnt[3:0]) : (first_q - cnt[3:0]);
    cur_addr  = base_q + ADDR_W'(cnt);
    in_xfer   = (state == ST_STORE) || (state == ST_LOAD) || (state == ST_BCD);
    beats     = (state == ST_BCD) ? 5'd3 : count;
    beat_live = in_xfer && (cnt < beats);

    // LOAD stays in its state until the last read has drained through the RAM.
    case (state)
      ST_STORE: end_cnt = count - 5'd1;
      ST_LOAD:  end_cnt = count + 5'(RAM_LATENCY) - 5'd1;
      ST_BCD:   end_cnt = 5'd2;
      default:  end_cnt = 5'd0;
    endcase

    case (cnt[1:0])
      2'd0:    bcd_digit = bcd_q / 8'd100;
      2'd1:    bcd_digit = (bcd_q / 8'd10) % 8'd10;
      default: bcd_digit = bcd_q % 8'd10;
    endcase
  end

  // Register file read follows the live store index; idle value is V0.
  assign reg_rd_idx = (state == ST_STORE) ? cur_idx : 4'd0;

  // Sequencer: accept a request in IDLE, step the beat counter, then pass through DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      cnt     <= 5'd0;
      op_q    <= 2'd0;
      first_q <= 4'd0;
      last_q  <= 4'd0;
      base_q  <= '0;
      bcd_q   <= 8'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            op_q    <= op;
            first_q <= first;
            last_q  <= last;
            base_q  <= base;
            bcd_q   <= bcd_val;
            cnt     <= 5'd0;
            case (op)
              OP_STORE: state <= ST_STORE;
              OP_LOAD:  state <= ST_LOAD;
              OP_BCD:   state <= ST_BCD;
              default:  state <= ST_DONE;
            endcase
          end
        end
        ST_STORE, ST_LOAD, ST_BCD: begin
          if (cnt == end_cnt) begin
            state <= ST_DONE;
          end else begin
            cnt <= cnt + 5'd1;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Registered RAM strobes, status flags and the optional I update, one cycle behind the sequencer.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      ram_en   <= 1'b0;
      ram_wr   <= 1'b0;
      ram_addr <= '0;
      ram_in   <= 8'd0;
      ld_idx_q <= 4'd0;
      i_wr     <= 1'b0;
      i_new    <= '0;
    end else begin
      busy   <= in_xfer;
      done   <= (state == ST_DONE);
      ram_en <= beat_live;
      ram_wr <= beat_live && (state != ST_LOAD);
      if (beat_live) begin
        ram_addr <= cur_addr;
        ld_idx_q <= cur_idx;
      end
      if (beat_live && (state == ST_STORE)) begin
        ram_in <= reg_rd_data;
      end else if (beat_live && (state == ST_BCD)) begin
        ram_in <= bcd_digit;
      end
      i_wr <= (QUIRK_INC_I != 0) && (state == ST_DONE) &&
              ((op_q == OP_STORE) || (op_q == OP_LOAD));
      if ((QUIRK_INC_I != 0) && (state == ST_DONE) &&
          ((op_q == OP_STORE) || (op_q == OP_LOAD))) begin
        i_new <= base_q + ADDR_W'(count);
      end
    end
  end

  // Read-return delay line: a read strobed in cycle k lands in the register file in cycle k+L.
  always_ff @(posedge clk) begin
    if (reset) begin
      dl_vld <= '0;
      for (int j = 0; j < RAM_LATENCY; j++) begin
        dl_idx[j] <= 4'd0;
      end
    end else begin
      dl_vld[0] <= ram_en && !ram_wr;
      dl_idx[0] <= ld_idx_q;
      for (int j = 1; j < RAM_LATENCY; j++) begin
        dl_vld[j] <= dl_vld[j-1];
        dl_idx[j] <= dl_idx[j-1];
      end
    end
  end

  assign reg_wr      = dl_vld[RAM_LATENCY-1];
  assign reg_wr_idx  = dl_idx[RAM_LATENCY-1];
  assign reg_wr_data = reg_wr ? ram_out : 8'd0;

endmodule
